alu_req_sequencer: RTL and testbench

Controller that shares the single combinational 8-bit ALU between two requesters. It arbitrates round-robin, registers the granted operands and opcode onto the ALU inputs, and waits a fixed settle time. It then captures ALU_Out/CarryOut and returns the result with a valid/ready response tagged by requester ID. It sits between the two command sources and the ALU instance.

---
 rtl/alu_seq_pkg.sv | 18 +
 rtl/alu_seq_rr_arb2.sv | 34 +++
 rtl/alu_req_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_req_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU request sequencer: FSM state encoding,
// default datapath widths and the result width.
package alu_seq_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_OP_W   = 4;
  localparam int unsigned RES_W      = 2 * DEF_DATA_W;

  // Settle counter width; covers SETTLE_CYCLES-1 for SETTLE_CYCLES up to 15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESP
  } seq_state_e;

endpackage

// File: rtl/alu_seq_rr_arb2.sv
// Two-way round-robin arbiter. The pointer holds the index of the most
// recently granted requester; on contention the other requester wins.
// The pointer resets to 1 so requester 0 wins the first contention.
module alu_seq_rr_arb2
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       ptr
);

  // One-hot grant: contention resolved by pointer, otherwise pass the lone request.
  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Pointer records the winner whenever a grant is actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b1;
    end else if (advance && (gnt != '0)) begin
      ptr <= gnt[1];
    end
  end

endmodule

// File: rtl/alu_req_sequencer.sv
// Shares one combinational ALU between two requesters: round-robin grant,
// registered operands onto the ALU, fixed settle time, captured response
// tagged with the requester ID.
// Optional feature macro: ALU_SEQ_STATS_EN (per-requester handshake counters).
module alu_req_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned OP_W          = DEF_OP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DATA_W-1:0]   req0_a,
  input  logic [DATA_W-1:0]   req0_b,
  input  logic [OP_W-1:0]     req0_op,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DATA_W-1:0]   req1_a,
  input  logic [DATA_W-1:0]   req1_b,
  input  logic [OP_W-1:0]     req1_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [OP_W-1:0]     alu_op,
  input  logic [2*DATA_W-1:0] alu_out,
  input  logic                alu_carry,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_result,
  output logic                rsp_carry,
  output logic                rsp_id,
`ifdef ALU_SEQ_STATS_EN
  output logic                busy,
  output logic [15:0]         stat_cnt0,
  output logic [15:0]         stat_cnt1
`else
  output logic                busy
`endif
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       gnt;
  logic             rr_ptr;
  logic             accept;
  logic             capture;
  logic             rsp_done;

  alu_seq_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .advance (accept),
    .gnt     (gnt),
    .ptr     (rr_ptr)
  );

  assign req0_ready = (state_q == ST_IDLE) && gnt[0];
  assign req1_ready = (state_q == ST_IDLE) && gnt[1];
  assign busy       = (state_q != ST_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt != '0) begin
          accept  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch and settle counter; ALU inputs only change on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      alu_a  <= gnt[1] ? req1_a  : req0_a;
      alu_b  <= gnt[1] ? req1_b  : req0_b;
      alu_op <= gnt[1] ? req1_op : req0_op;
      cnt_q  <= CNT_W'(SETTLE_CYCLES - 1);
    end else if ((state_q == ST_SETTLE) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Response capture. The arbiter pointer already holds the granted ID and
  // cannot move again before the capture, so it serves as the latched ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_id     <= 1'b0;
    end else if (capture) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_out;
      rsp_carry  <= alu_carry;
      rsp_id     <= rr_ptr;
    end else if (rsp_done) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  // Saturating count of completed response handshakes per requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else if (rsp_done) begin
      if (!rsp_id && (stat_cnt0 != '1)) begin
        stat_cnt0 <= stat_cnt0 + 16'd1;
      end
      if (rsp_id && (stat_cnt1 != '1)) begin
        stat_cnt1 <= stat_cnt1 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Directed testbench for alu_req_sequencer with a behavioural ALU model.
// One instance uses SETTLE_CYCLES=1, a second uses SETTLE_CYCLES=3.
module tb_alu_req_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // SETTLE_CYCLES=1 instance
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_carry;
  logic        rsp_valid, rsp_ready, rsp_carry, rsp_id, busy;
  logic [15:0] rsp_result;
  // SETTLE_CYCLES=3 instance
  logic        r3_req0_valid, r3_req1_valid, r3_req0_ready, r3_req1_ready;
  logic [7:0]  r3_req0_a, r3_req0_b, r3_req1_a, r3_req1_b;
  logic [3:0]  r3_req0_op, r3_req1_op;
  logic [7:0]  r3_alu_a, r3_alu_b;
  logic [3:0]  r3_alu_op;
  logic [15:0] r3_alu_out;
  logic        r3_alu_carry;
  logic        r3_rsp_valid, r3_rsp_ready, r3_rsp_carry, r3_rsp_id, r3_busy;
  logic [15:0] r3_rsp_result;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1, r3_stat_cnt0, r3_stat_cnt1;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Behavioural ALU: 0 add, 1 sub (carry = borrow), 2 mul, 3 and.
  function automatic logic [16:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    logic [8:0] s;
    logic [16:0] r;
    r = '0;
    case (op)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; r = {s[8], 8'h00, s[7:0]}; end
      4'h1: begin s = {1'b0, a} - {1'b0, b}; r = {s[8], 8'h00, s[7:0]}; end
      4'h2: r = {1'b0, a * b};
      4'h3: r = {1'b0, 8'h00, a & b};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb {alu_carry, alu_out}       = alu_f(alu_a, alu_b, alu_op);
  always_comb {r3_alu_carry, r3_alu_out} = alu_f(r3_alu_a, r3_alu_b, r3_alu_op);

  alu_req_sequencer #(.SETTLE_CYCLES(1), .DATA_W(8), .OP_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_id(rsp_id),
`ifdef ALU_SEQ_STATS_EN
    .busy(busy), .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`else
    .busy(busy)
`endif
  );

  alu_req_sequencer #(.SETTLE_CYCLES(3), .DATA_W(8), .OP_W(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(r3_req0_valid), .req0_ready(r3_req0_ready),
    .req0_a(r3_req0_a), .req0_b(r3_req0_b), .req0_op(r3_req0_op),
    .req1_valid(r3_req1_valid), .req1_ready(r3_req1_ready),
    .req1_a(r3_req1_a), .req1_b(r3_req1_b), .req1_op(r3_req1_op),
    .alu_a(r3_alu_a), .alu_b(r3_alu_b), .alu_op(r3_alu_op),
    .alu_out(r3_alu_out), .alu_carry(r3_alu_carry),
    .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready), .rsp_result(r3_rsp_result),
    .rsp_carry(r3_rsp_carry), .rsp_id(r3_rsp_id),
`ifdef ALU_SEQ_STATS_EN
    .busy(r3_busy), .stat_cnt0(r3_stat_cnt0), .stat_cnt1(r3_stat_cnt1)
`else
    .busy(r3_busy)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    r3_req0_valid = 0; r3_req1_valid = 0; r3_rsp_ready = 0;
    r3_req0_a = '0; r3_req0_b = '0; r3_req0_op = '0;
    r3_req1_a = '0; r3_req1_b = '0; r3_req1_op = '0;

    // Reset state
    #13;
    check("rst_outputs", {rsp_valid, rsp_carry, rsp_id, busy, req0_ready, req1_ready}, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_alu", {alu_a, alu_b, alu_op}, 0);
    rst = 1'b0;
    tick(); #1;
    check("idle_no_ready", {req0_ready, req1_ready, busy}, 0);

    // Single op, SETTLE_CYCLES=1: 0x0F + 0x01
    req0_valid = 1; req0_a = 8'h0F; req0_b = 8'h01; req0_op = 4'h0; rsp_ready = 1;
    #1;
    check("t2_ready", {req0_ready, req1_ready}, 2'b10);
    tick(); req0_valid = 0; #1;
    check("t2_settle", {req0_ready, busy, rsp_valid}, 3'b010);
    check("t2_alu_in", {alu_a, alu_b, alu_op}, {8'h0F, 8'h01, 4'h0});
    tick(); #1;
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp", {rsp_carry, rsp_id, rsp_result}, {1'b0, 1'b0, 16'h0010});
    tick(); #1;
    check("t2_back_idle", {rsp_valid, busy}, 0);

    // Asynchronous reset pulse clears retained values immediately
    rst = 1; #1;
    check("t1_rst_async", {alu_a, rsp_result, busy}, 0);
    tick(); rst = 0;

    // Contention: alternating grants starting with requester 0
    req0_valid = 1; req0_a = 8'h10; req0_b = 8'h20; req0_op = 4'h0;
    req1_valid = 1; req1_a = 8'h03; req1_b = 8'h04; req1_op = 4'h2;
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      k = 0; #1;
      while (!(req0_ready | req1_ready) && k < 6) begin tick(); #1; k++; end
      check("t3_grant_seen", {31'd0, req0_ready | req1_ready}, 1);
      check("t3_grant_id", {req0_ready, req1_ready}, (i % 2) ? 2'b01 : 2'b10);
      k = 0; tick(); #1;
      while (!rsp_valid && k < 6) begin tick(); #1; k++; end
      check("t3_rsp_id", {rsp_valid, rsp_id}, {1'b1, 1'(i % 2)});
      check("t3_rsp_result", rsp_result, (i % 2) ? 16'h000C : 16'h0030);
    end
    req0_valid = 0; req1_valid = 0;
    tick(); #1;
    check("t3_idle", busy, 0);

    // Backpressure: 0xFF + 0x02 from requester 1, carry out
    rsp_ready = 0;
    req1_valid = 1; req1_a = 8'hFF; req1_b = 8'h02; req1_op = 4'h0;
    #1;
    check("t4_ready", {req0_ready, req1_ready}, 2'b01);
    tick(); req1_valid = 0;
    tick(); #1;
    check("t4_rsp", {rsp_valid, rsp_carry, rsp_id, rsp_result}, {3'b111, 16'h0001});
    req0_valid = 1; req0_a = 8'h10; req0_b = 8'h20; req0_op = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      check("t4_hold", {rsp_valid, rsp_carry, rsp_id, req0_ready, req1_ready, rsp_result},
            {5'b11100, 16'h0001});
    end
    req0_valid = 0; rsp_ready = 1;
    tick(); #1;
    check("t4_handshake", {rsp_valid, busy}, 0);
    tick(); #1;
    check("t4_stay_idle", {rsp_valid, busy}, 0);
`ifdef ALU_SEQ_STATS_EN
    check("stats_a", {stat_cnt0, stat_cnt1}, {16'd2, 16'd3});
`endif

    // Settle length 3: 0x05 - 0x03, operand change after accept ignored
    r3_req0_valid = 1; r3_req0_a = 8'h05; r3_req0_b = 8'h03; r3_req0_op = 4'h1;
    r3_rsp_ready = 1;
    #1;
    check("t5_ready", r3_req0_ready, 1);
    tick(); r3_req0_a = 8'hAA; r3_req0_valid = 0; #1;
    check("t5_alu_a_held", r3_alu_a, 8'h05);
    k = 1;
    while (!r3_rsp_valid && k < 10) begin tick(); #1; k++; end
    check("t5_latency", k, 4);
    check("t5_rsp", {r3_rsp_valid, r3_rsp_carry, r3_rsp_id, r3_rsp_result}, {3'b100, 16'h0002});
    check("t5_alu_a_final", r3_alu_a, 8'h05);
    tick();

    // Reset mid-SETTLE with requester 1 granted
    req1_valid = 1; req1_a = 8'h33; req1_b = 8'h11; req1_op = 4'h3; rsp_ready = 1;
    #1;
    check("t6_ready1", {req0_ready, req1_ready}, 2'b01);
    tick(); req1_valid = 0; #1;
    check("t6_settle", busy, 1);
    rst = 1; #1;
    check("t6_rst_async", {rsp_valid, busy, alu_a}, 0);
    tick(); rst = 0;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      if (rsp_valid) k++;
    end
    check("t6_no_rsp", k, 0);
    req0_valid = 1; req0_a = 8'h0F; req0_b = 8'h01; req0_op = 4'h0;
    req1_valid = 1; req1_a = 8'h33; req1_b = 8'h11; req1_op = 4'h3;
    #1;
    check("t6_ptr_reset", {req0_ready, req1_ready}, 2'b10);
    tick(); req0_valid = 0; req1_valid = 0;
    tick(); #1;
    check("t6_rsp", {rsp_valid, rsp_id, rsp_result}, {2'b10, 16'h0010});
    tick(); #1;
`ifdef ALU_SEQ_STATS_EN
    check("stats_b", {stat_cnt0, stat_cnt1}, {16'd1, 16'd0});
`endif
    check("t6_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
